// File: rtl/telemetry_rx.sv
// Receive end of the eBike telemetry link: 8N1 UART deserializer plus an 8-byte
// packet framer that presents battery voltage, current and torque atomically.
//
// state    | meaning
// U_IDLE   | line idle, waiting for synced RX low
// U_START  | half-bit wait, then confirm start bit
// U_DATA   | sampling 8 data bits LSB first
// U_STOP   | sampling stop bit
// U_BREAK  | framing error seen, waiting for line high
// P_SYNC1  | hunting for 0xAA
// P_SYNC2  | expecting 0x55
// P_B_HI.. | payload bytes B_HI, B_LO, C_HI, C_LO, T_HI, T_LO
module telemetry_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        pkt_err
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_BREAK} ustate_t;
  typedef enum logic [2:0] {P_SYNC1, P_SYNC2, P_B_HI, P_B_LO,
                            P_C_HI, P_C_LO, P_T_HI, P_T_LO} pstate_t;

  ustate_t       ust;
  pstate_t       pst;
  logic          rx_meta, rx_s;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_byte;
  logic          byte_rdy, frame_err;
  logic [TW-1:0] to_cnt;
  logic [11:0]   sh_b, sh_c, sh_t;
  logic          commit;
  logic          in_pkt, hi_bad;

  // RX is asynchronous to clk; only rx_s is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ust       <= U_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      rx_byte   <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      case (ust)
        U_IDLE: begin
          if (!rx_s) begin
            ust      <= U_START;
            baud_cnt <= BW'(BAUD_DIV / 2 - 1);
          end
        end
        U_START: begin
          if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
          else if (rx_s) ust <= U_IDLE;
          else begin
            ust      <= U_DATA;
            baud_cnt <= BW'(BAUD_DIV - 1);
            bit_cnt  <= '0;
          end
        end
        U_DATA: begin
          if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
          else begin
            rx_byte  <= {rx_s, rx_byte[7:1]};
            baud_cnt <= BW'(BAUD_DIV - 1);
            if (bit_cnt == 3'd7) ust <= U_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
          else if (rx_s) begin
            byte_rdy <= 1'b1;
            ust      <= U_IDLE;
          end else begin
            frame_err <= 1'b1;
            ust       <= U_BREAK;
          end
        end
        U_BREAK: if (rx_s) ust <= U_IDLE;
        default: ust <= U_IDLE;
      endcase
    end
  end

  assign in_pkt = (pst != P_SYNC1) && (pst != P_SYNC2);
  assign hi_bad = (rx_byte[7:4] != 4'h0);

  // commit delays the output load by one clock so all three values change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pst        <= P_SYNC1;
      to_cnt     <= TW'(TIMEOUT - 1);
      sh_b       <= '0;
      sh_c       <= '0;
      sh_t       <= '0;
      commit     <= 1'b0;
      batt_v     <= '0;
      avg_curr   <= '0;
      avg_torque <= '0;
      pkt_vld    <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      commit  <= 1'b0;
      pkt_vld <= commit;
      pkt_err <= 1'b0;
      if (commit) begin
        batt_v     <= sh_b;
        avg_curr   <= sh_c;
        avg_torque <= sh_t;
      end
      if (byte_rdy) begin
        to_cnt <= TW'(TIMEOUT - 1);
        case (pst)
          P_SYNC1: if (rx_byte == 8'hAA) pst <= P_SYNC2;
          P_SYNC2: begin
            if (rx_byte == 8'h55) pst <= P_B_HI;
            else if (rx_byte != 8'hAA) pst <= P_SYNC1;
          end
          P_B_HI, P_C_HI, P_T_HI: begin
            if (hi_bad) begin
              pkt_err <= 1'b1;
              pst     <= P_SYNC1;
            end else begin
              case (pst)
                P_B_HI:  begin sh_b[11:8] <= rx_byte[3:0]; pst <= P_B_LO; end
                P_C_HI:  begin sh_c[11:8] <= rx_byte[3:0]; pst <= P_C_LO; end
                default: begin sh_t[11:8] <= rx_byte[3:0]; pst <= P_T_LO; end
              endcase
            end
          end
          P_B_LO: begin sh_b[7:0] <= rx_byte; pst <= P_C_HI; end
          P_C_LO: begin sh_c[7:0] <= rx_byte; pst <= P_T_HI; end
          P_T_LO: begin
            sh_t[7:0] <= rx_byte;
            commit    <= 1'b1;
            pst       <= P_SYNC1;
          end
          default: pst <= P_SYNC1;
        endcase
      end else if (frame_err && in_pkt) begin
        pkt_err <= 1'b1;
        pst     <= P_SYNC1;
      end else if (in_pkt) begin
        if (to_cnt == '0) begin
          pkt_err <= 1'b1;
          pst     <= P_SYNC1;
        end else begin
          to_cnt <= to_cnt - 1'b1;
        end
      end else begin
        to_cnt <= TW'(TIMEOUT - 1);
      end
    end
  end

endmodule

// File: tb/tb_telemetry_rx.sv
// Bench for telemetry_rx: drives 8N1 bytes and checks decoded packets against a
// queue of expected values filled as packets are sent.
module tb_telemetry_rx;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_vld, pkt_err;

  typedef struct {logic [11:0] b; logic [11:0] c; logic [11:0] t;} exp_t;
  exp_t exp_q[$];
  exp_t last;
  int tests = 0, fails = 0, vld_cnt = 0, err_cnt = 0;

  telemetry_rx #(.BAUD_DIV(BD), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .batt_v(batt_v), .avg_curr(avg_curr),
    .avg_torque(avg_torque), .pkt_vld(pkt_vld), .pkt_err(pkt_err));

  always #5 clk = ~clk;

  // Scoreboard: every pkt_vld pops one expected packet.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_vld && pkt_err) begin
        tests++; fails++;
        $display("FAIL vld_err_overlap: both pulses high at %0t", $time);
      end
      if (pkt_vld) begin
        vld_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_vld: got %h/%h/%h with empty queue", batt_v, avg_curr, avg_torque);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({batt_v, avg_curr, avg_torque} !== {e.b, e.c, e.t}) begin
            fails++;
            $display("FAIL pkt_values: got %h/%h/%h expected %h/%h/%h",
                     batt_v, avg_curr, avg_torque, e.b, e.c, e.t);
          end
        end
      end
      if (pkt_err) err_cnt++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk);
    rx = 1'b0;
    wait_clks(BD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BD);
    end
    rx = stop;
    wait_clks(BD);
    rx = 1'b1;
    if (!stop) wait_clks(2 * BD);
  endtask

  task automatic send_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    exp_t e;
    send_byte(8'hAA); send_byte(8'h55);
    send_byte({4'h0, b[11:8]}); send_byte(b[7:0]);
    send_byte({4'h0, c[11:8]}); send_byte(c[7:0]);
    send_byte({4'h0, t[11:8]});
    e.b = b; e.c = c; e.t = t;
    exp_q.push_back(e);
    last = e;
    send_byte(t[7:0]);
  endtask

  task automatic wait_vld(input int target);
    for (int i = 0; i < 200 && vld_cnt < target; i++) @(negedge clk);
    wait_clks(4);
  endtask

  task automatic check_held(input string name);
    tests++;
    if ({batt_v, avg_curr, avg_torque} !== {last.b, last.c, last.t}) begin
      fails++;
      $display("FAIL %s_held: got %h/%h/%h expected %h/%h/%h", name,
               batt_v, avg_curr, avg_torque, last.b, last.c, last.t);
    end
  endtask

  task automatic test_reset;
    wait_clks(3);
    tests++;
    if ({batt_v, avg_curr, avg_torque, pkt_vld, pkt_err} !== 38'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h/%h/%h vld=%b err=%b expected all 0",
               batt_v, avg_curr, avg_torque, pkt_vld, pkt_err);
    end
    rst_n = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_basic;
    int v0 = vld_cnt, e0 = err_cnt;
    send_pkt(12'hA98, 12'h123, 12'h456);
    wait_vld(v0 + 1);
    tests++;
    if (vld_cnt !== v0 + 1) begin fails++; $display("FAIL basic_vld_count: got %0d expected %0d", vld_cnt - v0, 1); end
    tests++;
    if (err_cnt !== e0) begin fails++; $display("FAIL basic_err_count: got %0d expected 0", err_cnt - e0); end
    check_held("basic");
  endtask

  task automatic test_resync;
    int v0 = vld_cnt, e0 = err_cnt;
    send_byte(8'h13); send_byte(8'hAA);
    send_pkt(12'hFFF, 12'h000, 12'hFFF);
    wait_vld(v0 + 1);
    tests++;
    if (vld_cnt !== v0 + 1) begin fails++; $display("FAIL resync_vld_count: got %0d expected 1", vld_cnt - v0); end
    tests++;
    if (err_cnt !== e0) begin fails++; $display("FAIL resync_err_count: got %0d expected 0", err_cnt - e0); end
    check_held("resync");
  endtask

  task automatic test_bad_nibble;
    int v0 = vld_cnt, e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h1A);
    wait_clks(10);
    tests++;
    if (err_cnt !== e0 + 1) begin fails++; $display("FAIL nibble_err_count: got %0d expected 1", err_cnt - e0); end
    tests++;
    if (vld_cnt !== v0) begin fails++; $display("FAIL nibble_vld_count: got %0d expected 0", vld_cnt - v0); end
    check_held("nibble");
    send_pkt(12'h123, 12'h456, 12'h789);
    wait_vld(v0 + 1);
    tests++;
    if (vld_cnt !== v0 + 1) begin fails++; $display("FAIL nibble_recover: got %0d expected 1", vld_cnt - v0); end
  endtask

  task automatic test_framing;
    int v0 = vld_cnt, e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    send_byte(8'h98); send_byte(8'h01); send_byte(8'h23, 1'b0);
    wait_clks(10);
    tests++;
    if (err_cnt !== e0 + 1) begin fails++; $display("FAIL framing_err_count: got %0d expected 1", err_cnt - e0); end
    tests++;
    if (vld_cnt !== v0) begin fails++; $display("FAIL framing_vld_count: got %0d expected 0", vld_cnt - v0); end
    send_byte(8'h11, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    wait_clks(5);
    rx = 1'b1;
    wait_clks(40);
    tests++;
    if (err_cnt !== e0 + 1) begin fails++; $display("FAIL silent_err_count: got %0d expected 1", err_cnt - e0); end
    check_held("framing");
    send_pkt(12'hABC, 12'h000, 12'h800);
    wait_vld(v0 + 1);
    tests++;
    if (vld_cnt !== v0 + 1) begin fails++; $display("FAIL framing_recover: got %0d expected 1", vld_cnt - v0); end
  endtask

  task automatic test_timeout;
    int v0 = vld_cnt, e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    wait_clks(950);
    tests++;
    if (err_cnt !== e0) begin fails++; $display("FAIL timeout_early: got %0d errors expected 0", err_cnt - e0); end
    wait_clks(150);
    tests++;
    if (err_cnt !== e0 + 1) begin fails++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - e0); end
    send_pkt(12'h5A5, 12'h0F0, 12'h321);
    wait_vld(v0 + 1);
    tests++;
    if (vld_cnt !== v0 + 1) begin fails++; $display("FAIL timeout_recover: got %0d expected 1", vld_cnt - v0); end
  endtask

  task automatic test_reset_mid_packet;
    int v0 = vld_cnt, e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
    send_byte(8'h98); send_byte(8'h01); send_byte(8'h23);
    @(negedge clk);
    rx = 1'b0;
    wait_clks(BD + 3 * BD);
    rst_n = 1'b0;
    rx = 1'b1;
    wait_clks(3);
    tests++;
    if ({batt_v, avg_curr, avg_torque, pkt_vld, pkt_err} !== 38'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got %h/%h/%h vld=%b err=%b expected all 0",
               batt_v, avg_curr, avg_torque, pkt_vld, pkt_err);
    end
    rst_n = 1'b1;
    wait_clks(3 * BD);
    tests++;
    if ({batt_v, avg_curr, avg_torque} !== 36'd0 || vld_cnt !== v0 || err_cnt !== e0) begin
      fails++;
      $display("FAIL midreset_after: got %h/%h/%h vld=%0d err=%0d expected zeros, no pulses",
               batt_v, avg_curr, avg_torque, vld_cnt - v0, err_cnt - e0);
    end
    send_pkt(12'hA98, 12'h123, 12'h456);
    wait_vld(v0 + 1);
    tests++;
    if (vld_cnt !== v0 + 1) begin fails++; $display("FAIL midreset_recover: got %0d expected 1", vld_cnt - v0); end
    check_held("midreset");
  endtask

  initial begin
    last.b = '0; last.c = '0; last.t = '0;
    test_reset();
    test_basic();
    test_resync();
    test_bad_nibble();
    test_framing();
    test_timeout();
    test_reset_mid_packet();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
